// File: rtl/key_filter_pkg.sv
// Shared types and constants for the push-button debounce stage.
// Timing defaults assume a 50 MHz system clock.
package key_filter_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_fsm_t;

   localparam int DEB_20MS  = 1_000_000;
   localparam int REP_500MS = 25_000_000;
   localparam int REP_100MS = 5_000_000;

   localparam int KEY_P = 0;
   localparam int KEY_N = 1;
   localparam int KEY_E = 2;
   localparam int KEY_M = 3;

   // One counter width serves debounce and repeat timing alike.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_filter_if.sv
// Key bus between the raw button pins, the debounce stage and its consumer.
// fsm_dbg carries each channel's FSM state (2 bits per key, key 0 in the LSBs).
interface key_filter_if #(
   parameter int N_KEYS = 4
);
   // key_in is raw and active-low; key_press is a single-cycle strobe with no
   // back-pressure (consumer must take it that cycle); key_state is a level.
   logic [N_KEYS-1:0]   key_in;
   logic [N_KEYS-1:0]   key_press;
   logic [N_KEYS-1:0]   key_state;
   logic [2*N_KEYS-1:0] fsm_dbg;

   modport master (
      output key_in,
      input  key_press,
      input  key_state,
      input  fsm_dbg
   );

   modport slave (
      input  key_in,
      output key_press,
      output key_state,
      output fsm_dbg
   );
endinterface

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and saturating counter.
// Auto-repeat strobes are built only when KEY_FILTER_REPEAT_EN is defined.
module key_filter_ch
   import key_filter_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_20MS,
   parameter int REP_DELAY  = REP_500MS,
   parameter int REP_PERIOD = REP_100MS
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     key_raw,
   output logic     press,
   output logic     held,
   output key_fsm_t fsm_state
);

   localparam int CW = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic          sync_q1;
   logic          sync_n;
   key_fsm_t      state;
   key_fsm_t      state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [CW-1:0] cnt_inc;
   logic          deb_hit;
   logic          press_nx;
   logic          rep_fire;
   logic          press_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_n  <= 1'b1;
      end else begin
         sync_q1 <= key_raw;
         sync_n  <= sync_q1;
      end
   end

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
   // Acceptance is judged on the count this cycle completes, so the level is
   // taken DEB_CYCLES+1 edges after the first synchroniser capture.
   assign deb_hit = (cnt_inc >= DEB_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RELEASED;
         cnt     <= '0;
         press_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         press_q <= press_nx | rep_fire;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      press_nx = 1'b0;
      case (state)
         RELEASED: begin
            if (!sync_n) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (sync_n) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else if (deb_hit) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
               press_nx = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         PRESSED: begin
            if (sync_n) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!sync_n) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (deb_hit) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = RELEASED;
            cnt_nx   = '0;
         end
      endcase
   end

`ifdef KEY_FILTER_REPEAT_EN
   logic [CW-1:0] rep_cnt;
   logic [CW-1:0] rep_last;
   logic          rep_first;

   assign rep_last = rep_first ? CW'(REP_DELAY - 1) : CW'(REP_PERIOD - 1);
   assign rep_fire = (state == PRESSED) && !sync_n && (rep_cnt >= rep_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if ((state != PRESSED) || sync_n) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_fire) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         rep_cnt <= (rep_cnt == CNT_MAX) ? rep_cnt : rep_cnt + CW'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign press     = press_q;
   assign held      = (state == PRESSED) || (state == RELEASE_WAIT);
   assign fsm_state = state;

endmodule

// File: rtl/key_filter.sv
// Debounce and press-strobe extraction for the clock's four push-buttons.
// Auto-repeat is enabled by defining KEY_FILTER_REPEAT_EN.
module key_filter
   import key_filter_pkg::*;
#(
   parameter int N_KEYS     = 4,
   parameter int DEB_CYCLES = DEB_20MS,
   parameter int REP_DELAY  = REP_500MS,
   parameter int REP_PERIOD = REP_100MS
) (
   input  logic         clk,
   input  logic         rst_n,
   key_filter_if.slave  kbus
);

   logic [N_KEYS-1:0]   press;
   logic [N_KEYS-1:0]   held;
   logic [2*N_KEYS-1:0] dbg;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_fsm_t st;

      key_filter_ch #(
         .DEB_CYCLES (DEB_CYCLES),
         .REP_DELAY  (REP_DELAY),
         .REP_PERIOD (REP_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .key_raw   (kbus.key_in[i]),
         .press     (press[i]),
         .held      (held[i]),
         .fsm_state (st)
      );

      assign dbg[2*i +: 2] = st;
   end

   assign kbus.key_press = press;
   assign kbus.key_state = held;
   assign kbus.fsm_dbg   = dbg;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
// Expectations follow KEY_FILTER_REPEAT_EN the same way the design does.
module tb_key_filter;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   key_filter_if #(.N_KEYS(4)) kif ();

   key_filter #(
      .N_KEYS     (4),
      .DEB_CYCLES (4),
      .REP_DELAY  (10),
      .REP_PERIOD (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kbus  (kif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] exp_press, input logic [3:0] exp_state);
      total++;
      assert (kif.key_press === exp_press)
      else begin
         bad++;
         $error("FAIL %s key_press: observed=%b expected=%b", tag, kif.key_press, exp_press);
      end
      total++;
      assert (kif.key_state === exp_state)
      else begin
         bad++;
         $error("FAIL %s key_state: observed=%b expected=%b", tag, kif.key_state, exp_state);
      end
   endtask

   task automatic run(input int n, input logic [3:0] exp_press, input logic [3:0] exp_state,
                      input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, exp_press, exp_state);
      end
   endtask

   initial begin
      logic       rep_on;
      logic [3:0] ep;
      logic [3:0] es;
      total = 0;
      bad   = 0;
`ifdef KEY_FILTER_REPEAT_EN
      rep_on = 1'b1;
`else
      rep_on = 1'b0;
`endif

      // reset and idle
      rst_n      = 1'b0;
      kif.key_in = 4'hF;
      tick();
      tick();
      chk("reset", 4'h0, 4'h0);
      total++;
      assert (kif.fsm_dbg === 8'h00)
      else begin
         bad++;
         $error("FAIL reset fsm_dbg: observed=%h expected=%h", kif.fsm_dbg, 8'h00);
      end
      rst_n = 1'b1;
      run(100, 4'h0, 4'h0, "idle");

      // clean press on key 0, held 20 cycles, then released
      kif.key_in = 4'hE;
      run(5, 4'h0, 4'h0, "clean_wait");
      run(1, 4'h1, 4'h1, "clean_strobe");
      run(14, 4'h0, 4'h1, "clean_hold");
      kif.key_in = 4'hF;
      run(5, 4'h0, 4'h1, "clean_rel_wait");
      run(1, 4'h0, 4'h0, "clean_released");
      run(5, 4'h0, 4'h0, "clean_idle");

      // bounce on key 1: low 3, high 1, ten times
      for (int r = 0; r < 10; r++) begin
         kif.key_in = 4'hD;
         run(3, 4'h0, 4'h0, "bounce_low");
         kif.key_in = 4'hF;
         run(1, 4'h0, 4'h0, "bounce_high");
      end
      kif.key_in = 4'hD;
      run(5, 4'h0, 4'h0, "bounce_settle");
      run(1, 4'h2, 4'h2, "bounce_strobe");
      run(3, 4'h0, 4'h2, "bounce_hold");
      kif.key_in = 4'hF;
      run(5, 4'h0, 4'h2, "bounce_rel_wait");
      run(4, 4'h0, 4'h0, "bounce_released");

      // keys 0 and 3 together
      kif.key_in = 4'h6;
      run(5, 4'h0, 4'h0, "simul_wait");
      run(1, 4'h9, 4'h9, "simul_strobe");
      run(3, 4'h0, 4'h9, "simul_hold");
      kif.key_in = 4'hF;
      run(5, 4'h0, 4'h9, "simul_rel_wait");
      run(3, 4'h0, 4'h0, "simul_released");

      // reset two cycles into PRESS_WAIT, key still held
      kif.key_in = 4'hE;
      run(4, 4'h0, 4'h0, "rstmid_wait");
      rst_n = 1'b0;
      #1;
      chk("rstmid_async", 4'h0, 4'h0);
      run(2, 4'h0, 4'h0, "rstmid_in_reset");
      rst_n = 1'b1;
      run(5, 4'h0, 4'h0, "rstmid_redeb");
      run(1, 4'h1, 4'h1, "rstmid_strobe");
      run(3, 4'h0, 4'h1, "rstmid_hold");

      // reset while pressed: outputs drop at once, held key re-debounces
      rst_n = 1'b0;
      #1;
      chk("rsthold_async", 4'h0, 4'h0);
      tick();
      rst_n = 1'b1;
      run(5, 4'h0, 4'h0, "rsthold_redeb");
      run(1, 4'h1, 4'h1, "rsthold_strobe");
      run(2, 4'h0, 4'h1, "rsthold_hold");
      kif.key_in = 4'hF;
      run(5, 4'h0, 4'h1, "rsthold_rel_wait");
      run(3, 4'h0, 4'h0, "rsthold_released");

      // key 2 held 30 cycles past acceptance; repeats at +10, +13, ...
      kif.key_in = 4'hB;
      run(5, 4'h0, 4'h0, "rep_wait");
      run(1, 4'h4, 4'h4, "rep_press");
      for (int i = 1; i <= 38; i++) begin
         tick();
         ep = 4'h0;
         if (rep_on && (i >= 10) && (((i - 10) % 3) == 0) && (i <= 32))
            ep = 4'h4;
         es = (i < 36) ? 4'h4 : 4'h0;
         chk($sformatf("rep_p%0d", i), ep, es);
         if (i == 30)
            kif.key_in = 4'hF;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
